// File: rtl/ax_branch_cycle_decider_pkg.sv
// Shared types for the approximate-branch decider: channel state, datapath
// widths at their default sizes, and the PC-to-region-tag mapping.
package AxDeciderTypes;

  localparam int AX_FETCH_WIDTH = 2;
  localparam int AX_NUM_CH      = 4;
  localparam int AX_CNT_WIDTH   = 16;
  localparam int AX_TAG_WIDTH   = 12;
  localparam int AX_PC_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } AxChState;

  typedef logic [$clog2(AX_NUM_CH)-1:0] AxChIdPath;
  typedef logic [AX_CNT_WIDTH-1:0]      AxCntPath;
  typedef logic [AX_TAG_WIDTH-1:0]      AxTagPath;

  function automatic AxTagPath ToAxTag(input logic [AX_PC_WIDTH-1:0] pc);
    return AxTagPath'(pc >> 2);
  endfunction

endpackage

// File: rtl/ax_decider_channel.sv
// One tracked approximate region: IDLE/COUNT/EXPIRED state, saturating
// budget counter, region tag and the per-lane tag compare for re-arming.
module ax_decider_channel
  import AxDeciderTypes::*;
#(
  parameter int FETCH_WIDTH = AX_FETCH_WIDTH,
  parameter int CNT_WIDTH   = AX_CNT_WIDTH,
  parameter int TAG_WIDTH   = AX_TAG_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             stall,
  input  logic                             cfgMode,
  input  logic [CNT_WIDTH-1:0]             cfgBudget,
  input  logic                             alloc,
  input  logic [TAG_WIDTH-1:0]             allocTag,
  input  logic [FETCH_WIDTH-1:0]           laneBegin,
  input  logic [FETCH_WIDTH*TAG_WIDTH-1:0] laneTag,
  input  logic                             exitHit,
  input  logic [CNT_WIDTH-1:0]             takenCnt,
  output logic [FETCH_WIDTH-1:0]           laneMatch,
  output logic                             isActive,
  output logic                             isCount,
  output logic                             isExpired
);

  AxChState             state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [TAG_WIDTH-1:0] tag;
  logic [CNT_WIDTH:0]   cntNext;
  logic                 rearm;
  logic                 reached;

  always_comb begin
    laneMatch = '0;
    for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
      laneMatch[l] = (state != IDLE) && laneBegin[l] &&
                     (laneTag[l*TAG_WIDTH +: TAG_WIDTH] == tag);
    end
  end

  // One extra bit so the increment can never wrap before the clamp.
  always_comb begin
    rearm   = |laneMatch;
    cntNext = {1'b0, cnt} + (cfgMode ? {1'b0, takenCnt} : (CNT_WIDTH+1)'(1));
    reached = cntNext >= {1'b0, cfgBudget};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= '0;
      tag   <= '0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (alloc) begin
            state <= COUNT;
            cnt   <= '0;
            tag   <= allocTag;
          end
        end
        COUNT: begin
          if (rearm) begin
            cnt <= '0;
          end else if (reached) begin
            state <= EXPIRED;
            cnt   <= cfgBudget;
          end else begin
            cnt <= cntNext[CNT_WIDTH-1:0];
          end
        end
        EXPIRED: begin
          if (rearm) begin
            state <= COUNT;
            cnt   <= '0;
          end else if (exitHit) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign isActive  = (state != IDLE);
  assign isCount   = (state == COUNT);
  assign isExpired = (state == EXPIRED);

endmodule

// File: rtl/ax_branch_cycle_decider.sv
// Multi-channel approximate-loop branch decider: allocates region channels on
// buffer begin hits and overrides per-lane taken decisions on AXBTB hits.
module ax_branch_cycle_decider
  import AxDeciderTypes::*;
#(
  parameter int FETCH_WIDTH = AX_FETCH_WIDTH,
  parameter int NUM_CH      = AX_NUM_CH,
  parameter int CNT_WIDTH   = AX_CNT_WIDTH,
  parameter int TAG_WIDTH   = AX_TAG_WIDTH,
  parameter int PC_WIDTH    = AX_PC_WIDTH,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            stall,
  input  logic                            cfgMode,
  input  logic [CNT_WIDTH-1:0]            cfgBudget,
  input  logic [FETCH_WIDTH-1:0]          laneValid,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0] lanePC,
  input  logic [FETCH_WIDTH-1:0]          bufferHit,
  input  logic [FETCH_WIDTH-1:0]          axHit,
  input  logic [FETCH_WIDTH*CH_W-1:0]     axChId,
  input  logic [FETCH_WIDTH-1:0]          brPredTaken,
  output logic [FETCH_WIDTH-1:0]          decidTaken,
  output logic                            allocValid,
  output logic [CH_W-1:0]                 allocChId,
  output logic                            allocFail,
  output logic [NUM_CH-1:0]               chActive
);

  logic [FETCH_WIDTH*TAG_WIDTH-1:0] laneTag;
  logic [FETCH_WIDTH-1:0]           laneBegin;
  logic [FETCH_WIDTH-1:0]           laneKnown;
  logic [CH_W-1:0]                  laneCh [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]           chLaneMatch [NUM_CH];
  logic [CNT_WIDTH-1:0]             chTaken [NUM_CH];
  logic [NUM_CH-1:0]                chCount, chExpired, chExit, chAlloc;
  logic                             budgetOn;
  logic                             candFound, freeFound, doAlloc, doFail;
  logic [TAG_WIDTH-1:0]             candTag;
  logic [CH_W-1:0]                  freeId;
  logic                             unusedPcBits;

  assign budgetOn     = (cfgBudget != '0);
  assign unusedPcBits = ^lanePC;

  always_comb begin
    laneTag   = '0;
    laneBegin = '0;
    for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
      laneTag[l*TAG_WIDTH +: TAG_WIDTH] = lanePC[l*PC_WIDTH+2 +: TAG_WIDTH];
      laneBegin[l] = laneValid[l] & bufferHit[l];
      laneCh[l]    = axChId[l*CH_W +: CH_W];
    end
  end

  // Forced decisions come from registered channel state; forced-taken lanes
  // also feed the iteration-mode counter of their channel.
  always_comb begin
    decidTaken = brPredTaken;
    chExit     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) chTaken[c] = '0;
    for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
      if (laneValid[l] && axHit[l]) begin
        chExit[laneCh[l]] = 1'b1;
        if (budgetOn && chCount[laneCh[l]]) begin
          decidTaken[l]       = 1'b1;
          chTaken[laneCh[l]]  = chTaken[laneCh[l]] + CNT_WIDTH'(1);
        end else if (budgetOn && chExpired[laneCh[l]]) begin
          decidTaken[l] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    laneKnown = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) laneKnown = laneKnown | chLaneMatch[c];
    candFound = 1'b0;
    candTag   = '0;
    for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
      if (!candFound && laneBegin[l] && !laneKnown[l]) begin
        candFound = 1'b1;
        candTag   = laneTag[l*TAG_WIDTH +: TAG_WIDTH];
      end
    end
    freeFound = 1'b0;
    freeId    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!freeFound && !chActive[c]) begin
        freeFound = 1'b1;
        freeId    = CH_W'(c);
      end
    end
    doAlloc = candFound && freeFound && !stall && budgetOn && !flush;
    doFail  = candFound && !freeFound && !stall && budgetOn && !flush;
    chAlloc = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) chAlloc[c] = doAlloc && (freeId == CH_W'(c));
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      allocValid <= 1'b0;
      allocChId  <= '0;
      allocFail  <= 1'b0;
    end else begin
      allocValid <= doAlloc;
      allocFail  <= doFail;
      if (doAlloc) allocChId <= freeId;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    ax_decider_channel #(
      .FETCH_WIDTH(FETCH_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH)
    ) uCh (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .stall    (stall),
      .cfgMode  (cfgMode),
      .cfgBudget(cfgBudget),
      .alloc    (chAlloc[c]),
      .allocTag (candTag),
      .laneBegin(laneBegin),
      .laneTag  (laneTag),
      .exitHit  (chExit[c]),
      .takenCnt (chTaken[c]),
      .laneMatch(chLaneMatch[c]),
      .isActive (chActive[c]),
      .isCount  (chCount[c]),
      .isExpired(chExpired[c])
    );
  end

endmodule

// File: doc/ax_branch_cycle_decider.md
Name: ax_branch_cycle_decider

Overview:
- Parametrised successor to the single-lane cycle-limited approximate branch decider and the begin-cycle counter.
- Tracks up to NUM_CH concurrent approximate loop regions, each with its own counter and budget mode. Budget mode is either cycle-limited or iteration-limited.
- Per fetch lane, overrides the predictor's taken decision for approximate-BTB hits: forced taken while the region's budget lasts, forced not-taken once it expires.
- Sits in the fetch stage next to the AXBTB and buffer. Feeds the next-PC logic.

Parameters:
- FETCH_WIDTH, 2, number of fetch lanes.
- NUM_CH, 4, number of concurrently tracked approximate regions.
- CNT_WIDTH, 16, per-channel counter/budget width.
- TAG_WIDTH, 12, region tag width, taken from PC[TAG_WIDTH+1:2].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush; clears all channels.
- stall  in  1  fetch stall; freezes counters and allocation.
- cfgMode  in  1  0 = cycle budget, 1 = iteration budget.
- cfgBudget  in  CNT_WIDTH  budget; 0 disables the block (pure passthrough).
- laneValid  in  FETCH_WIDTH  lane valid.
- lanePC  in  FETCH_WIDTH x PC width  lane PC.
- bufferHit  in  FETCH_WIDTH  region-begin hit from the buffer.
- axHit  in  FETCH_WIDTH  approximate-BTB hit.
- axChId  in  FETCH_WIDTH x log2(NUM_CH)  channel the AXBTB entry belongs to.
- brPredTaken  in  FETCH_WIDTH  predictor decision.
- decidTaken  out  FETCH_WIDTH  final decision.
- allocValid  out  1  channel allocated this cycle.
- allocChId  out  log2(NUM_CH)  allocated channel.
- allocFail  out  1  begin hit dropped because no channel was free.
- chActive  out  NUM_CH  channel state != IDLE.

Behaviour:
Reset and flush
- On rst: all channels IDLE, counters 0, tags 0; allocValid/allocFail 0; chActive 0.
- flush has the same effect as rst on channel state. flush takes priority over all other events in that cycle.

Channel FSM, per channel
- States: IDLE, COUNT, EXPIRED.
- IDLE -> COUNT on allocation. Counter is set to 0 and the tag is latched.
- COUNT -> EXPIRED at the clock edge where the updated counter is >= cfgBudget.
- EXPIRED -> IDLE at the edge following a cycle in which any valid lane has axHit with axChId equal to this channel (the exit decision was issued).
- A valid bufferHit whose tag matches an active channel re-arms it: counter set to 0, state COUNT. No new allocation is made.

Allocation
- Candidate is the lowest-index lane with laneValid & bufferHit whose tag matches no active channel. At most one allocation per cycle.
- The candidate goes to the lowest-index IDLE channel. allocValid/allocChId are registered and pulse the cycle after the edge.
- If no channel is IDLE, allocFail pulses for 1 cycle and nothing changes.
- No allocation while stall is high or cfgBudget == 0.

Counting (CNT_WIDTH bits, saturating at cfgBudget)
- Mode 0: +1 per non-stalled cycle while in COUNT.
- Mode 1: + popcount of lanes forced-taken for this channel this cycle. The counter clamps at cfgBudget; no wrap.
- Stall freezes all counters and FSM transitions except rst/flush.

Decision (combinational, same cycle, uses registered channel state)
- If laneValid & axHit and the channel axChId is in COUNT: decidTaken = 1.
- If that channel is EXPIRED: decidTaken = 0.
- Otherwise (IDLE channel, no axHit, invalid lane, or cfgBudget == 0): decidTaken = brPredTaken.
- Lanes after a forced-not-taken lane in the same cycle still pass their own decision. Lane squashing belongs to next-PC logic.

Simultaneous events
- Re-arm and expiry on the same channel in the same cycle: re-arm wins.
- Exit decision and re-arm in the same cycle: re-arm wins (state COUNT, counter 0).
- A cfgBudget change mid-count applies from the next compare; a channel already over the new budget expires at the next edge.

Decomposition:
- Package AxDeciderTypes holds:
  - AxChState enum (IDLE, COUNT, EXPIRED);
  - AxChIdPath, AxCntPath, AxTagPath;
  - function ToAxTag(PC).
- Sub-module ax_decider_channel: one channel's FSM, counter, tag and compare. It is instantiated NUM_CH times.
- The top level holds allocation priority encoding, the per-lane decision mux and the allocValid/allocChId/allocFail registers.

Test Plan:
- Mode 0, budget 5: bufferHit lane0 PC 0x1000, then axHit chId 0 every cycle → allocValid/allocChId=0 the cycle after the edge; decidTaken=1 for 5 cycles; EXPIRED then decidTaken=0 once; channel IDLE the following cycle.
- Mode 1, budget 3, FETCH_WIDTH 2: both lanes axHit chId 1 each cycle → counter 2, then 3 (clamped); forced taken for 2 cycles, then not-taken.
- 4 channels active, 5th distinct bufferHit → allocFail pulse; existing counters unaffected; decisions for the dropped region pass brPredTaken.
- Re-hit tag of ch 2 at count 4 (budget 5) → count 0, still COUNT; 5 more taken decisions before expiry.
- Stall 3 cycles mid-count → counter and state frozen; flush → all chActive=0; next axHit passes brPredTaken.
- cfgBudget=0 → no allocation; decidTaken==brPredTaken on all lanes for random stimulus; rst mid-COUNT → chActive=0 at the next cycle.
